// File: rtl/amm_addr_router.sv
// Avalon-MM address router: one master fanned out to SLV_CNT windowed slaves.
// Pipelined in-order reads, dummy responder and decode-error pulse for holes.
module amm_addr_router #(
    parameter int                 SLV_CNT               = 2,
    parameter int                 ADDR_W                = 32,
    parameter int                 DATA_W                = 16,
    parameter int unsigned        SLV_BASE [SLV_CNT]    = '{32'h0, 32'h100},
    parameter int unsigned        SLV_SIZE [SLV_CNT]    = '{32'h100, 32'h100},
    parameter int                 MAX_PENDING           = 4,
    parameter logic [DATA_W-1:0]  DEFAULT_RDATA         = '1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_W-1:0]         mst_address,
    input  logic                      mst_read,
    input  logic                      mst_write,
    input  logic [DATA_W-1:0]         mst_writedata,
    output logic [DATA_W-1:0]         mst_readdata,
    output logic                      mst_readdatavalid,
    output logic                      mst_waitrequest,
    output logic [SLV_CNT*ADDR_W-1:0] slv_address,
    output logic [SLV_CNT-1:0]        slv_read,
    output logic [SLV_CNT-1:0]        slv_write,
    output logic [SLV_CNT*DATA_W-1:0] slv_writedata,
    input  logic [SLV_CNT*DATA_W-1:0] slv_readdata,
    input  logic [SLV_CNT-1:0]        slv_readdatavalid,
    input  logic [SLV_CNT-1:0]        slv_waitrequest,
    output logic                      decode_err_o
);

    localparam int AW1   = ADDR_W + 1;
    localparam int TGT_W = $clog2(SLV_CNT + 1);
    localparam int CNT_W = $clog2(MAX_PENDING + 1);
    localparam logic [TGT_W-1:0] DUMMY   = TGT_W'(SLV_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    logic [CNT_W-1:0]   pend_cnt_q, pend_cnt_d;
    logic [TGT_W-1:0]   pend_tgt_q, pend_tgt_d;
    logic               dummy_rv_q, dummy_rv_d;
    logic               derr_q, derr_d;

    logic [TGT_W-1:0]   tgt;
    logic [SLV_CNT-1:0] hit;
    logic               mapped;
    logic               swait;
    logic               stall;
    logic               rd_acc;
    logic               wr_acc;
    logic               rv_sel;
    logic [DATA_W-1:0]  rd_sel;
    logic               resp;

    assign slv_address   = {SLV_CNT{mst_address}};
    assign slv_writedata = {SLV_CNT{mst_writedata}};

    // Window decode; descending scan so the lowest matching index wins.
    always_comb begin
        logic [AW1-1:0] lo;
        logic [AW1-1:0] hi;
        logic [AW1-1:0] a;
        tgt = DUMMY;
        hit = '0;
        a   = {1'b0, mst_address};
        for (int i = SLV_CNT - 1; i >= 0; i--) begin
            lo = AW1'(SLV_BASE[i]);
            hi = lo + AW1'(SLV_SIZE[i]);
            if (a >= lo && a < hi) begin
                tgt = TGT_W'(i);
            end
        end
        for (int i = 0; i < SLV_CNT; i++) begin
            hit[i] = (tgt == TGT_W'(i));
        end
        mapped = (tgt != DUMMY);
    end

    // Mux the selected slave's stall and the pending target's response.
    always_comb begin
        swait  = 1'b0;
        rv_sel = dummy_rv_q;
        rd_sel = DEFAULT_RDATA;
        for (int i = 0; i < SLV_CNT; i++) begin
            if (hit[i]) begin
                swait = slv_waitrequest[i];
            end
            if (pend_tgt_q == TGT_W'(i)) begin
                rv_sel = slv_readdatavalid[i];
                rd_sel = slv_readdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake, forwarding and next-state logic; a write beats a read.
    always_comb begin
        stall = mst_read & ~mst_write &
                ((pend_cnt_q == CNT_MAX) |
                 ((pend_cnt_q != '0) & (tgt != pend_tgt_q)));
        mst_waitrequest = rst_i | stall | (mapped & swait);
        rd_acc = ~rst_i & mst_read & ~mst_write & ~mst_waitrequest;
        wr_acc = ~rst_i & mst_write & ~mst_waitrequest;
        slv_read  = (rst_i | ~mst_read | mst_write | stall) ? '0 : hit;
        slv_write = (rst_i | ~mst_write) ? '0 : hit;

        resp = ~rst_i & (pend_cnt_q != '0) & rv_sel;
        mst_readdatavalid = resp;
        mst_readdata      = rd_sel;

        pend_cnt_d = pend_cnt_q;
        if (rd_acc && !resp && pend_cnt_q != CNT_MAX) begin
            pend_cnt_d = pend_cnt_q + CNT_W'(1);
        end else if (resp && !rd_acc) begin
            pend_cnt_d = pend_cnt_q - CNT_W'(1);
        end
        pend_tgt_d = rd_acc ? tgt : pend_tgt_q;
        dummy_rv_d = rd_acc & ~mapped;
        derr_d     = (rd_acc | wr_acc) & ~mapped;
    end

    // Pending-read tracking, dummy responder and decode-error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_cnt_q <= '0;
            pend_tgt_q <= '0;
            dummy_rv_q <= 1'b0;
            derr_q     <= 1'b0;
        end else begin
            pend_cnt_q <= pend_cnt_d;
            pend_tgt_q <= pend_tgt_d;
            dummy_rv_q <= dummy_rv_d;
            derr_q     <= derr_d;
        end
    end

    assign decode_err_o = derr_q;

endmodule

// File: doc/amm_addr_router.md
Name: amm_addr_router

Overview:
- Parametrised successor to the single-master Avalon-MM demux: one master port fans out to SLV_CNT slave ports.
- Each slave has a programmable base/size window, plus a built-in dummy responder for unmapped addresses.
- Adds pipelined reads: up to MAX_PENDING outstanding reads, in-order response routing, stall on target change, and a decode-error pulse.
- Sits between the JTAG-to-AMM bridge master and the register/memory slaves.

Parameters:
SLV_CNT, 2, number of slave ports (>=1)
ADDR_W, 32, address width
DATA_W, 16, data width
SLV_BASE, {0,'h100}, int array [SLV_CNT], window base per slave
SLV_SIZE, {'h100,'h100}, int array [SLV_CNT], window size per slave (>0)
MAX_PENDING, 4, max outstanding reads (>=1)
DEFAULT_RDATA, all ones, read data returned for unmapped reads

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mst_address  in  ADDR_W  master address
mst_read  in  1  master read request
mst_write  in  1  master write request
mst_writedata  in  DATA_W  master write data
mst_readdata  out  DATA_W  routed read data
mst_readdatavalid  out  1  routed read-data valid
mst_waitrequest  out  1  stall to master
slv_address  out  SLV_CNT*ADDR_W  address broadcast to each slave
slv_read  out  SLV_CNT  per-slave read
slv_write  out  SLV_CNT  per-slave write
slv_writedata  out  SLV_CNT*DATA_W  write data broadcast to each slave
slv_readdata  in  SLV_CNT*DATA_W  per-slave read data
slv_readdatavalid  in  SLV_CNT  per-slave read valid
slv_waitrequest  in  SLV_CNT  per-slave stall
decode_err_o  out  1  one-cycle pulse per accepted unmapped access

Behaviour:
- Interface: one clock clk_i. Reset rst_i is synchronous and active-high.
- Decode: slave i is hit when SLV_BASE[i] <= addr < SLV_BASE[i]+SLV_SIZE[i]. Compute the sum at ADDR_W+1 bits so it cannot wrap. On overlapping windows the lowest index wins. No hit selects target DUMMY (index SLV_CNT).
- Request forwarding:
  - slv_address and slv_writedata are broadcast to all slaves.
  - slv_read[i] = mst_read & hit[i] & ~stall.
  - slv_write[i] = mst_write & hit[i].
  - If mst_read and mst_write are both high, the write wins: it is forwarded, the read is dropped and not counted.
- State: pend_cnt (0..MAX_PENDING) and pend_tgt (0..SLV_CNT).
- Stall condition: stall = mst_read & ((pend_cnt==MAX_PENDING) | (pend_cnt!=0 & tgt!=pend_tgt)). Reads therefore never overlap across targets, which keeps responses in order.
- mst_waitrequest:
  - Mapped target: stall | slv_waitrequest[tgt].
  - DUMMY target: stall only.
  - Writes are never stalled by stall.
- Read accept = mst_read & ~mst_write & ~mst_waitrequest. On accept, pend_tgt <= tgt.
- Read response:
  - resp = slv_readdatavalid[pend_tgt] when pend_cnt!=0 and pend_tgt is mapped.
  - resp = dummy_rv when pend_tgt is DUMMY.
  - mst_readdatavalid = resp. mst_readdata = slv_readdata[pend_tgt], or DEFAULT_RDATA for DUMMY.
  - Routing is combinational: zero added latency for mapped slaves.
- Ignored valids: readdatavalid from any slave other than pend_tgt, or any valid while pend_cnt==0, is ignored and not forwarded.
- Dummy responder: dummy_rv is registered and is 1 exactly one cycle after each accepted unmapped read, so back-to-back unmapped reads give back-to-back valids. An unmapped write is accepted with no wait and discarded.
- pend_cnt update:
  - +1 on accept, -1 on resp.
  - Both in the same cycle: unchanged.
  - pend_cnt never exceeds MAX_PENDING and never goes below 0.
- decode_err_o is registered and pulses 1 cycle after any accepted unmapped read or write.
- Reset: pend_cnt=0, pend_tgt=0, dummy_rv=0, decode_err_o=0. While rst_i=1:
  - slv_read and slv_write are 0.
  - mst_waitrequest=1.
  - mst_readdatavalid=0.
  - Responses still in flight from slaves after reset are discarded (pend_cnt==0).

Test Plan:
- Default params, write 0x1234 @0x0004 then @0x0104 -> slv_write[0] then slv_write[1] each pulse 1 cycle with matching data; decode_err_o stays 0.
- Read @0x0300 (unmapped) -> mst_waitrequest=0; mst_readdatavalid=1 with 0xFFFF next cycle; decode_err_o pulses once.
- Four back-to-back reads to slave 0, whose valids return 3 cycles later -> 5th read stalled (waitrequest=1) until the first valid; all 4 data delivered in order.
- Read slave 0 (pending), then immediate read slave 1 -> slave-1 read held with slv_read[1]=0 until slave-0 valid returns; then forwarded.
- Spurious slv_readdatavalid[1] while pend_tgt=0 -> mst_readdatavalid stays 0; pend_cnt unchanged.
- Reset asserted with 2 reads pending, slave valids arriving afterwards -> no mst_readdatavalid; next read is accepted normally.
